// File: rtl/ticsat_req_adapter.sv
// -----------------------------------------------------------------------------
// ticsat_req_adapter
//
// Request/response front end for the FP32 pipelined TicSAT systolic array.
// Bus-side requests are buffered in a request FIFO and issued one per cycle as
// registered in_val/in_idx/cmd beats into the array. Read requests are tagged
// through a READ_LATENCY-deep valid pipe, and array `out` is captured into a
// response FIFO when the tag emerges. A credit count makes sure every issued
// read already owns a response slot, so captured data is never dropped.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   req_valid/req_ready        request handshake (ready = request FIFO not full)
//   req_cmd/idx/val/read       request payload; req_read asks for `out` back
//   rsp_valid/rsp_ready        response handshake, rsp_data = FIFO head
//   sa_in_val/in_idx/cmd       registered beat driven into the array
//   sa_out                     array result, sampled READ_LATENCY after a read
//   busy                       requests queued, reads in flight, responses held
//                              or a beat currently on sa_cmd
// -----------------------------------------------------------------------------
package ticsat_pkg;
  typedef enum logic [2:0] {
    CMD_NOP    = 3'd0,
    CMD_LOAD_W = 3'd1,
    CMD_LOAD_A = 3'd2,
    CMD_STEP   = 3'd3,
    CMD_READ   = 3'd4
  } command_t;
endpackage

module ticsat_req_adapter
  import ticsat_pkg::*;
#(
  parameter int       SA_SIZE      = -1,
  parameter int       REQ_DEPTH    = 4,
  parameter int       RSP_DEPTH    = 2,
  parameter int       READ_LATENCY = 1,
  parameter command_t IDLE_CMD     = command_t'(0),
  // Guarded so an un-overridden SA_SIZE still elaborates to a legal width.
  localparam int      IDX_W        = (SA_SIZE < 2) ? 1 : $clog2(SA_SIZE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  command_t         req_cmd,
  input  logic [IDX_W-1:0] req_idx,
  input  logic [31:0]      req_val,
  input  logic             req_read,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [31:0]      sa_in_val,
  output logic [IDX_W-1:0] sa_in_idx,
  output command_t         sa_cmd,
  input  logic [31:0]      sa_out,
  output logic             busy
);

  localparam int RQ_AW = $clog2(REQ_DEPTH);
  localparam int RS_AW = $clog2(RSP_DEPTH);
  localparam int CNT_W = RS_AW + 1;

  typedef struct packed {
    command_t         cmd;
    logic [IDX_W-1:0] idx;
    logic [31:0]      val;
    logic             read;
  } req_t;

  // ---------------------------------------------------------------------------
  // Request FIFO. Pointers carry one extra wrap bit: equal means empty, MSB
  // different with equal low bits means full.
  // ---------------------------------------------------------------------------
  req_t           rq_mem_q [REQ_DEPTH];
  logic [RQ_AW:0] rq_wr_q, rq_rd_q;
  logic           rq_empty, rq_full, rq_push, rq_pop;
  req_t           rq_head;

  assign rq_empty  = (rq_wr_q == rq_rd_q);
  assign rq_full   = (rq_wr_q[RQ_AW] != rq_rd_q[RQ_AW]) &&
                     (rq_wr_q[RQ_AW-1:0] == rq_rd_q[RQ_AW-1:0]);
  // No pass-through when full, even if the head pops this cycle.
  assign req_ready = !rq_full;
  assign rq_push   = req_valid && !rq_full;
  assign rq_head   = rq_mem_q[rq_rd_q[RQ_AW-1:0]];

  // NOTE: storage arrays carry no reset; only pointers define which entries
  // are valid, so clearing the data would just cost reset fan-out.
  always_ff @(posedge clk) begin
    if (rq_push) begin
      rq_mem_q[rq_wr_q[RQ_AW-1:0]] <= '{cmd: req_cmd, idx: req_idx,
                                        val: req_val, read: req_read};
    end
  end

  // NOTE: sequential state is updated with non-blocking '<=' so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rq_wr_q <= '0;
      rq_rd_q <= '0;
    end else begin
      if (rq_push) rq_wr_q <= rq_wr_q + (RQ_AW+1)'(1);
      if (rq_pop)  rq_rd_q <= rq_rd_q + (RQ_AW+1)'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Credits: response slots not yet owned by a held response or an issued read.
  // A read at the head waits for a credit and stalls everything behind it.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] inflight_q, inflight_d, rs_count, credits;
  logic             capture;

  assign credits = CNT_W'(RSP_DEPTH) - rs_count - inflight_q;
  assign rq_pop  = !rq_empty && (!rq_head.read || (credits != '0));

  // NOTE: combinational logic uses blocking '=' and assigns a default first,
  // so no path leaves the output unassigned and no latch is inferred.
  always_comb begin
    inflight_d = inflight_q;
    if (rq_pop && rq_head.read) inflight_d = inflight_d + CNT_W'(1);
    if (capture)                inflight_d = inflight_d - CNT_W'(1);
  end

  // ---------------------------------------------------------------------------
  // Issue stage: one registered beat per pop, IDLE_CMD otherwise.
  // ---------------------------------------------------------------------------
  command_t         sa_cmd_q;
  logic [31:0]      sa_in_val_q;
  logic [IDX_W-1:0] sa_in_idx_q;
  logic             sa_read_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sa_cmd_q    <= IDLE_CMD;
      sa_in_val_q <= '0;
      sa_in_idx_q <= '0;
      sa_read_q   <= 1'b0;
      inflight_q  <= '0;
    end else begin
      inflight_q <= inflight_d;
      if (rq_pop) begin
        sa_cmd_q    <= rq_head.cmd;
        sa_in_val_q <= rq_head.val;
        sa_in_idx_q <= rq_head.idx;
        sa_read_q   <= rq_head.read;
      end else begin
        sa_cmd_q    <= IDLE_CMD;
        sa_in_val_q <= '0;
        sa_in_idx_q <= '0;
        sa_read_q   <= 1'b0;
      end
    end
  end

  assign sa_cmd    = sa_cmd_q;
  assign sa_in_val = sa_in_val_q;
  assign sa_in_idx = sa_in_idx_q;

  // ---------------------------------------------------------------------------
  // Read tag pipe: capture fires READ_LATENCY cycles after the read beat.
  // ---------------------------------------------------------------------------
  generate
    if (READ_LATENCY == 0) begin : g_lat0
      assign capture = sa_read_q;
    end else begin : g_latn
      logic [READ_LATENCY-1:0] tag_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          tag_q <= '0;
        end else begin
          tag_q[0] <= sa_read_q;
          for (int i = 1; i < READ_LATENCY; i++) tag_q[i] <= tag_q[i-1];
        end
      end
      assign capture = tag_q[READ_LATENCY-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Response FIFO. Credits guarantee a free slot on every capture.
  // ---------------------------------------------------------------------------
  logic [31:0]    rs_mem_q [RSP_DEPTH];
  logic [RS_AW:0] rs_wr_q, rs_rd_q;
  logic           rs_pop;

  assign rs_count  = rs_wr_q - rs_rd_q;
  assign rsp_valid = (rs_wr_q != rs_rd_q);
  assign rs_pop    = rsp_valid && rsp_ready;
  // Empty FIFO presents zero rather than stale storage.
  assign rsp_data  = rsp_valid ? rs_mem_q[rs_rd_q[RS_AW-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (capture) rs_mem_q[rs_wr_q[RS_AW-1:0]] <= sa_out;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs_wr_q <= '0;
      rs_rd_q <= '0;
    end else begin
      if (capture) rs_wr_q <= rs_wr_q + (RS_AW+1)'(1);
      if (rs_pop)  rs_rd_q <= rs_rd_q + (RS_AW+1)'(1);
    end
  end

  assign busy = !rq_empty || (inflight_q != '0) || rsp_valid ||
                (sa_cmd_q != IDLE_CMD);

endmodule

// File: tb/tb_ticsat_req_adapter.sv
// -----------------------------------------------------------------------------
// Testbench for ticsat_req_adapter (SA_SIZE=4, REQ_DEPTH=4, RSP_DEPTH=2,
// READ_LATENCY=1). A queue-based reference model tracks queued requests, the
// beat on the array port, outstanding reads and held responses; every cycle
// the DUT outputs are compared with it. The stand-in array echoes the in_val
// of the beat one cycle earlier on sa_out, so read data equals the request's
// req_val.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ticsat_req_adapter;
  import ticsat_pkg::*;

  localparam int       SA_SIZE      = 4;
  localparam int       REQ_DEPTH    = 4;
  localparam int       RSP_DEPTH    = 2;
  localparam int       READ_LATENCY = 1;
  localparam int       IDX_W        = 2;
  localparam command_t IDLE         = CMD_NOP;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  command_t         req_cmd = CMD_NOP;
  logic [IDX_W-1:0] req_idx = '0;
  logic [31:0]      req_val = '0;
  logic             req_read = 1'b0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [31:0]      rsp_data;
  logic [31:0]      sa_in_val;
  logic [IDX_W-1:0] sa_in_idx;
  command_t         sa_cmd;
  logic [31:0]      sa_out = '0;
  logic             busy;

  always #5 clk = ~clk;

  ticsat_req_adapter #(
    .SA_SIZE(SA_SIZE), .REQ_DEPTH(REQ_DEPTH), .RSP_DEPTH(RSP_DEPTH),
    .READ_LATENCY(READ_LATENCY), .IDLE_CMD(IDLE)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_idx(req_idx), .req_val(req_val), .req_read(req_read),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .sa_in_val(sa_in_val), .sa_in_idx(sa_in_idx), .sa_cmd(sa_cmd),
    .sa_out(sa_out), .busy(busy)
  );

  typedef struct {
    command_t         cmd;
    logic [IDX_W-1:0] idx;
    logic [31:0]      val;
    bit               rd;
  } req_s;

  // Reference model state
  req_s        rq_m[$];     // accepted, not yet issued
  req_s        beat_m;      // beat on the array port this cycle
  int          pend_m[$];   // cycles left until capture, one per issued read
  logic [31:0] rsp_m[$];    // responses held

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [31:0] arr_pipe = '0;
  int          rd_beat_cyc = -1;
  int          rsp_rise_cyc = -1;
  logic [31:0] rsp_rise_data = '0;
  bit          prev_rsp_valid = 1'b0;
  int          n_rd_beats = 0;
  int          n_beats = 0;
  int          n_rsp_seen = 0;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
               tag, act, exp, cyc);
    end
  endtask

  function automatic req_s idle_beat();
    req_s b;
    b.cmd = IDLE; b.idx = '0; b.val = '0; b.rd = 1'b0;
    return b;
  endfunction

  function automatic bit model_idle();
    return (rq_m.size() == 0) && (pend_m.size() == 0) &&
           (rsp_m.size() == 0) && (beat_m.cmd == IDLE);
  endfunction

  // One clock cycle: entered at a falling edge with inputs already driven.
  task automatic step();
    req_s nb, cur;
    bit   issue, cap, acc;
    int   credits;
    sa_out = arr_pipe;
    #1;
    if (reset) begin
      rq_m.delete(); pend_m.delete(); rsp_m.delete();
      beat_m = idle_beat();
    end
    check("req_ready", req_ready, rq_m.size() < REQ_DEPTH);
    check("rsp_valid", rsp_valid, rsp_m.size() > 0);
    if (rsp_m.size() > 0) check("rsp_data", rsp_data, rsp_m[0]);
    check("sa_cmd", sa_cmd, beat_m.cmd);
    check("sa_in_idx", sa_in_idx, beat_m.idx);
    check("sa_in_val", sa_in_val, beat_m.val);
    check("busy", busy, (rq_m.size() != 0) || (pend_m.size() != 0) ||
                        (rsp_m.size() != 0) || (beat_m.cmd != IDLE));
    // Observations used by the directed scenarios.
    if (sa_cmd == CMD_READ) begin rd_beat_cyc = cyc; n_rd_beats++; end
    if (sa_cmd != IDLE) n_beats++;
    if (rsp_valid) n_rsp_seen++;
    if (rsp_valid && !prev_rsp_valid) begin
      rsp_rise_cyc  = cyc;
      rsp_rise_data = rsp_data;
    end
    prev_rsp_valid = rsp_valid;
    arr_pipe = sa_in_val;
    if (!reset) begin
      credits = RSP_DEPTH - rsp_m.size() - pend_m.size();
      issue   = (rq_m.size() > 0) && (!rq_m[0].rd || credits > 0);
      acc     = req_valid && (rq_m.size() < REQ_DEPTH);
      cap     = (pend_m.size() > 0) && (pend_m[0] == 0);
      if (cap) void'(pend_m.pop_front());
      foreach (pend_m[i]) pend_m[i]--;
      if ((rsp_m.size() > 0) && rsp_ready) void'(rsp_m.pop_front());
      if (cap) rsp_m.push_back(sa_out);
      if (issue) begin
        nb = rq_m.pop_front();
        if (nb.rd) pend_m.push_back(READ_LATENCY);
      end else begin
        nb = idle_beat();
      end
      beat_m = nb;
      if (acc) begin
        cur.cmd = req_cmd; cur.idx = req_idx; cur.val = req_val; cur.rd = req_read;
        rq_m.push_back(cur);
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Hold a request valid until the model says it was accepted (bounded).
  task automatic push(input command_t c, input logic [IDX_W-1:0] idx,
                      input logic [31:0] val, input bit rd);
    bit acc = 1'b0;
    req_valid = 1'b1; req_cmd = c; req_idx = idx; req_val = val; req_read = rd;
    for (int i = 0; i < 50 && !acc; i++) begin
      acc = (rq_m.size() < REQ_DEPTH);
      step();
    end
    req_valid = 1'b0;
    check("push_accepted", acc, 1);
  endtask

  task automatic drain();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 100 && !model_idle(); i++) step();
    check("drain_done", model_idle(), 1);
    step();
  endtask

  initial begin
    @(negedge clk);
    // Reset values, then 10 quiet cycles.
    idle(2);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("rsp_data_rst", rsp_data, 0);
      step();
    end

    // Write burst: four back-to-back writes, fp32 1.0 .. 4.0.
    rsp_ready = 1'b1;
    begin
      logic [31:0] vals [4];
      vals[0] = 32'h3F800000; vals[1] = 32'h40000000;
      vals[2] = 32'h40400000; vals[3] = 32'h40800000;
      for (int i = 0; i < 4; i++) push(CMD_LOAD_W, IDX_W'(i), vals[i], 1'b0);
    end
    idle(5);

    // Single read: response 2 cycles after the beat, data from the array.
    rd_beat_cyc = -1; rsp_rise_cyc = -1;
    push(CMD_READ, 2'd1, 32'hC0490FDB, 1'b1);
    idle(6);
    check("rd_latency", rsp_rise_cyc - rd_beat_cyc, READ_LATENCY + 1);
    check("rd_data", rsp_rise_data, 32'hC0490FDB);

    // Credit limit: three reads with the consumer stalled.
    rsp_ready = 1'b0;
    n_rd_beats = 0;
    push(CMD_READ, 2'd0, 32'h11110000, 1'b1);
    push(CMD_READ, 2'd1, 32'h22220000, 1'b1);
    push(CMD_READ, 2'd2, 32'h33330000, 1'b1);
    idle(4);
    check("credit_block", n_rd_beats, 2);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    idle(3);
    check("credit_release", n_rd_beats, 3);
    drain();

    // Full FIFO behind a blocked read.
    rsp_ready = 1'b0;
    push(CMD_READ, 2'd0, 32'hA0000001, 1'b1);
    push(CMD_READ, 2'd1, 32'hA0000002, 1'b1);
    idle(3);
    push(CMD_READ, 2'd2, 32'hA0000003, 1'b1);
    push(CMD_LOAD_A, 2'd0, 32'hB0000001, 1'b0);
    push(CMD_LOAD_A, 2'd1, 32'hB0000002, 1'b0);
    push(CMD_LOAD_A, 2'd2, 32'hB0000003, 1'b0);
    n_beats = 0;
    req_valid = 1'b1; req_cmd = CMD_LOAD_A; req_idx = 2'd3;
    req_val = 32'hB0000004; req_read = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("full_ready", req_ready, 0);
      step();
    end
    check("full_stall", n_beats, 0);
    rsp_ready = 1'b1;
    push(CMD_LOAD_A, 2'd3, 32'hB0000004, 1'b0);
    drain();

    // Reset while a read is on the array port.
    rsp_ready = 1'b1;
    push(CMD_READ, 2'd3, 32'hDEAD0001, 1'b1);
    step();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    n_rsp_seen = 0;
    idle(5);
    check("rst_no_rsp", n_rsp_seen, 0);
    rsp_ready = 1'b0;
    n_rd_beats = 0;
    push(CMD_READ, 2'd0, 32'h5EED0001, 1'b1);
    push(CMD_READ, 2'd1, 32'h5EED0002, 1'b1);
    idle(4);
    check("rst_credits", n_rd_beats, RSP_DEPTH);
    drain();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      req_valid = ($urandom_range(0, 9) < 6);
      req_read  = ($urandom_range(0, 9) < 4);
      req_cmd   = req_read ? CMD_READ : command_t'($urandom_range(1, 3));
      req_idx   = IDX_W'($urandom_range(0, SA_SIZE - 1));
      req_val   = $urandom;
      rsp_ready = $urandom_range(0, 1);
      step();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
